// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ requesters.
// Define MUL_ARBITER_TIMEOUT_EN to compile in the WAIT-state watchdog.
module mul_arbiter #(
    parameter int N           = 16,
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] mcand_in,
    input  logic [NREQ*N-1:0] mlier_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [2*N:0]      result,
    output logic              busy,
    output logic              mul_start,
    output logic [N-1:0]      mul_mcand,
    output logic [N-1:0]      mul_mlier,
    input  logic [2*N:0]      mul_prodt,
    input  logic              mul_valid,
    output logic              timeout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] pick;
    logic          found;
    logic          cap;
    logic          expire;
    int            pick_off;

    always_comb begin
        int j;
        logic [PW-1:0] jj;
        j     = 0;
        jj    = '0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            j  = (int'(ptr) + k) % NREQ;
            jj = PW'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                pick  = jj;
            end
        end
    end

    assign pick_off = int'(pick) * N;

    // mul_start high means the multiplier is only now starting, so any
    // valid seen in that cycle belongs to an older operation.
    assign cap = (state == WAIT) && mul_valid && !mul_start;

`ifdef MUL_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wd_cnt;
    logic          wd_hit;

    assign expire = (state == WAIT) && !cap &&
                    (wd_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            wd_hit <= 1'b0;
        end else begin
            if (state == WAIT)
                wd_cnt <= wd_cnt + CW'(1);
            else
                wd_cnt <= '0;
            if (state == ISSUE)
                wd_hit <= 1'b0;
            else if (expire)
                wd_hit <= 1'b1;
        end
    end

    assign timeout_err = (state == DONE) && wd_hit;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cap || expire) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            result    <= '0;
            mul_start <= 1'b0;
            mul_mcand <= '0;
            mul_mlier <= '0;
        end else begin
            state     <= state_nx;
            mul_start <= (state == ISSUE);
            if (state == IDLE && found) begin
                sel       <= pick;
                mul_mcand <= mcand_in[pick_off +: N];
                mul_mlier <= mlier_in[pick_off +: N];
            end
            if (cap)
                result <= mul_prodt;
            else if (expire)
                result <= '0;
            if (state == DONE)
                ptr <= (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
        end
    end

    assign gnt  = (state == ISSUE) ? (NREQ'(1) << sel) : '0;
    assign done = (state == DONE) ? (NREQ'(1) << sel) : '0;
    assign busy = (state != IDLE);

endmodule
